// File: rtl/sn_sched_pkg.sv
// sn_sched_pkg
//   Shared types and constants for the stochastic-number generator scheduler.
//   Holds the FSM state encoding, the completion status codes, the generator
//   lane geometry (4 lanes x 4-bit operands) and the default bitstream length.
package sn_sched_pkg;

   localparam int SN_LANES   = 4;
   localparam int SN_BITS    = 4;
   localparam int SN_LEN_DEF = 16;
   localparam int RUN_CNT_W  = 5;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_RUN       = 3'd3,
      S_STOP      = 3'd4,
      S_DONE      = 3'd5
   } state_e;

   // Code 3 is reserved and never produced.
   typedef enum logic [1:0] {
      ST_OK      = 2'd0,
      ST_ABORTED = 2'd1,
      ST_TIMEOUT = 2'd2
   } status_e;

   typedef logic [SN_LANES-1:0][SN_BITS-1:0] operand_t;

endpackage

// File: rtl/sn_gen_sched_arbiter.sv
// rr_arbiter
//   Combinational round-robin pick. Scans the request vector starting at
//   ptr_i and wrapping modulo NREQ; the first requester found wins.
//   Ports:
//     req_i  - request vector
//     ptr_i  - index that has highest priority this round
//     gnt_o  - one-hot winner (all zero when nothing requests)
//     idx_o  - winner index (0 when nothing requests)
//     any_o  - at least one request present
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
)(
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   // One extra bit so ptr + offset never overflows before the wrap.
   logic [IW:0]   sum;
   logic [IW-1:0] k;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      sum   = '0;
      k     = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, ptr_i} + (IW+1)'(i);
         if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
         end
         k = sum[IW-1:0];
         if (!any_o && req_i[k]) begin
            any_o    = 1'b1;
            gnt_o[k] = 1'b1;
            idx_o    = k;
         end
      end
   end

endmodule

// File: rtl/sn_gen_sched.sv
// sn_gen_sched
//   Round-robin scheduler that shares one 4-lane stochastic-number generator
//   among NREQ requesters. Arbitrates, latches the winner's operands, pulses
//   start/stop into the generator, tracks its busy flag and returns a
//   one-cycle completion pulse with a status code. All outputs registered.
//   Ports:
//     i_clk_sched, i_rst_sched    - clock, synchronous active-high reset
//     i_req, i_x_bn, i_abort      - per-requester request, operands, abort
//     i_gen_busy                  - generator "generating" flag
//     o_grant, o_owner            - one-hot owner and its index
//     o_done, o_status            - completion pulse to owner, status code
//     o_gen_start, o_gen_stop     - one-cycle pulses to the generator
//     o_gen_x                     - latched operands to the generator
//     o_busy, o_run_cnt           - not idle, cycles spent in RUN
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no owner; arbitrate among requests
//   LAUNCH    | start pulse out, run counter cleared
//   WAIT_BUSY | waiting up to WAIT_MAX cycles for the generator to go busy
//   RUN       | generator busy; counting cycles until busy falls
//   STOP      | stop pulse on entry; wait for busy to fall
//   DONE      | completion pulse to owner with status; grant still held
module sn_gen_sched
   import sn_sched_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int SN_LEN   = SN_LEN_DEF,
   parameter int WAIT_MAX = 4,
   localparam int IW      = $clog2(NREQ)
)(
   input  logic                                         i_clk_sched,
   input  logic                                         i_rst_sched,
   input  logic [NREQ-1:0]                              i_req,
   input  logic [NREQ-1:0][SN_LANES-1:0][SN_BITS-1:0]   i_x_bn,
   input  logic [NREQ-1:0]                              i_abort,
   input  logic                                         i_gen_busy,
   output logic [NREQ-1:0]                              o_grant,
   output logic [IW-1:0]                                o_owner,
   output logic [NREQ-1:0]                              o_done,
   output logic [1:0]                                   o_status,
   output logic                                         o_gen_start,
   output logic                                         o_gen_stop,
   output logic [SN_LANES-1:0][SN_BITS-1:0]             o_gen_x,
   output logic                                         o_busy,
   output logic [RUN_CNT_W-1:0]                         o_run_cnt
);

   localparam logic [RUN_CNT_W-1:0] RUN_MAX   = RUN_CNT_W'(SN_LEN + 2);
   localparam logic [7:0]           WAIT_LOAD = 8'(WAIT_MAX - 1);

   state_e                 state_q,   state_d;
   logic [IW-1:0]          rr_ptr_q,  rr_ptr_d;
   logic [NREQ-1:0]        grant_q,   grant_d;
   logic [IW-1:0]          owner_q,   owner_d;
   logic [NREQ-1:0]        done_q,    done_d;
   status_e                status_q,  status_d;
   logic                   start_q,   start_d;
   logic                   stop_q,    stop_d;
   operand_t               gen_x_q,   gen_x_d;
   logic                   busy_q,    busy_d;
   logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
   logic [7:0]             wait_cnt_q, wait_cnt_d;

   logic [NREQ-1:0]        arb_gnt;
   logic [IW-1:0]          arb_idx;
   logic                   arb_any;
   logic                   owner_abort;
   logic [RUN_CNT_W-1:0]   run_cnt_inc;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req_i (i_req),
      .ptr_i (rr_ptr_q),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   assign owner_abort = i_abort[owner_q];
   assign run_cnt_inc = (run_cnt_q == RUN_MAX) ? run_cnt_q : run_cnt_q + RUN_CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      owner_d    = owner_q;
      status_d   = status_q;
      gen_x_d    = gen_x_q;
      run_cnt_d  = run_cnt_q;
      wait_cnt_d = wait_cnt_q;

      unique case (state_q)
         S_IDLE: begin
            if (arb_any) begin
               state_d   = S_LAUNCH;
               grant_d   = arb_gnt;
               owner_d   = arb_idx;
               gen_x_d   = i_x_bn[arb_idx];
               rr_ptr_d  = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
               run_cnt_d = '0;
               status_d  = ST_OK;
            end
         end
         S_LAUNCH: begin
            wait_cnt_d = WAIT_LOAD;
            if (owner_abort) begin
               state_d  = S_STOP;
               status_d = ST_ABORTED;
            end else begin
               state_d  = S_WAIT_BUSY;
            end
         end
         S_WAIT_BUSY: begin
            // Abort outranks both busy rising and the wait expiry.
            if (owner_abort) begin
               state_d  = S_STOP;
               status_d = ST_ABORTED;
            end else if (i_gen_busy) begin
               state_d  = S_RUN;
            end else if (wait_cnt_q == 8'd0) begin
               state_d  = S_STOP;
               status_d = ST_TIMEOUT;
            end else begin
               wait_cnt_d = wait_cnt_q - 8'd1;
            end
         end
         S_RUN: begin
            run_cnt_d = run_cnt_inc;
            // Busy falling is a completion and wins over a same-cycle abort.
            if (!i_gen_busy) begin
               state_d  = S_DONE;
               status_d = ST_OK;
            end else if (owner_abort) begin
               state_d  = S_STOP;
               status_d = ST_ABORTED;
            end else if (run_cnt_inc == RUN_MAX) begin
               state_d  = S_STOP;
               status_d = ST_TIMEOUT;
            end
         end
         S_STOP: begin
            if (!i_gen_busy) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase

      // Pulse outputs are derived from the upcoming state so they stay registered.
      start_d = (state_d == S_LAUNCH);
      stop_d  = (state_d == S_STOP) && (state_q != S_STOP);
      done_d  = (state_d == S_DONE) ? grant_d : '0;
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk_sched) begin
      if (i_rst_sched) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         grant_q    <= '0;
         owner_q    <= '0;
         done_q     <= '0;
         status_q   <= ST_OK;
         start_q    <= 1'b0;
         stop_q     <= 1'b0;
         gen_x_q    <= '0;
         busy_q     <= 1'b0;
         run_cnt_q  <= '0;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_q    <= grant_d;
         owner_q    <= owner_d;
         done_q     <= done_d;
         status_q   <= status_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         gen_x_q    <= gen_x_d;
         busy_q     <= busy_d;
         run_cnt_q  <= run_cnt_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign o_grant     = grant_q;
   assign o_owner     = owner_q;
   assign o_done      = done_q;
   assign o_status    = status_q;
   assign o_gen_start = start_q;
   assign o_gen_stop  = stop_q;
   assign o_gen_x     = gen_x_q;
   assign o_busy      = busy_q;
   assign o_run_cnt   = run_cnt_q;

endmodule

// File: tb/tb_sn_gen_sched.sv
// tb_sn_gen_sched
//   Directed bench for sn_gen_sched (NREQ=4, SN_LEN=16, WAIT_MAX=4).
//   The generator busy flag is driven cycle by cycle from the stimulus.
module tb_sn_gen_sched;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [3:0]             req;
   logic [3:0][3:0][3:0]   x_bn;
   logic [3:0]             abort;
   logic                   gen_busy;

   logic [3:0]             o_grant;
   logic [1:0]             o_owner;
   logic [3:0]             o_done;
   logic [1:0]             o_status;
   logic                   o_gen_start;
   logic                   o_gen_stop;
   logic [3:0][3:0]        o_gen_x;
   logic                   o_busy;
   logic [4:0]             o_run_cnt;

   logic [15:0]            xs [4];
   int                     n_tests = 0;
   int                     n_fail  = 0;

   sn_gen_sched #(
      .NREQ     (4),
      .SN_LEN   (16),
      .WAIT_MAX (4)
   ) dut (
      .i_clk_sched (clk),
      .i_rst_sched (rst),
      .i_req       (req),
      .i_x_bn      (x_bn),
      .i_abort     (abort),
      .i_gen_busy  (gen_busy),
      .o_grant     (o_grant),
      .o_owner     (o_owner),
      .o_done      (o_done),
      .o_status    (o_status),
      .o_gen_start (o_gen_start),
      .o_gen_stop  (o_gen_stop),
      .o_gen_x     (o_gen_x),
      .o_busy      (o_busy),
      .o_run_cnt   (o_run_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached, got no finish, expected finish");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk_eq({tag, "_grant"},   o_grant,     0);
      chk_eq({tag, "_owner"},   o_owner,     0);
      chk_eq({tag, "_done"},    o_done,      0);
      chk_eq({tag, "_status"},  o_status,    0);
      chk_eq({tag, "_start"},   o_gen_start, 0);
      chk_eq({tag, "_stop"},    o_gen_stop,  0);
      chk_eq({tag, "_gen_x"},   o_gen_x,     0);
      chk_eq({tag, "_busy"},    o_busy,      0);
      chk_eq({tag, "_run_cnt"}, o_run_cnt,   0);
   endtask

   // From an IDLE cycle: one full OK job with the generator busy for len cycles,
   // ending in the following IDLE cycle.
   task automatic job_ok(input int own, input int len);
      logic [3:0] oh;
      oh = 4'b0001 << own;
      tick();
      chk_eq("job_start",    o_gen_start, 1);
      chk_eq("job_grant",    o_grant,     oh);
      chk_eq("job_owner",    o_owner,     own);
      chk_eq("job_x_launch", o_gen_x,     xs[own]);
      chk_eq("job_cnt_clr",  o_run_cnt,   0);
      tick();
      chk_eq("job_start_1cyc", o_gen_start, 0);
      gen_busy = 1'b1;
      repeat (len) tick();
      chk_eq("job_busy_run", o_busy, 1);
      chk_eq("job_no_done",  o_done, 0);
      gen_busy = 1'b0;
      tick();
      chk_eq("job_done",     o_done,     oh);
      chk_eq("job_status",   o_status,   0);
      chk_eq("job_run_cnt",  o_run_cnt,  len);
      chk_eq("job_grant_dn", o_grant,    oh);
      chk_eq("job_x_done",   o_gen_x,    xs[own]);
      chk_eq("job_no_stop",  o_gen_stop, 0);
      tick();
      chk_eq("job_idle_grant", o_grant, 0);
      chk_eq("job_idle_done",  o_done,  0);
      chk_eq("job_idle_busy",  o_busy,  0);
   endtask

   task automatic launch(input int own, input logic [3:0] rq);
      req = rq;
      tick();
      req = 4'b0000;
      chk_eq("launch_start", o_gen_start, 1);
      chk_eq("launch_owner", o_owner,     own);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      xs[0] = 16'h1234;
      xs[1] = 16'h5A5A;
      xs[2] = 16'h3F08;
      xs[3] = 16'hD00D;
      for (int i = 0; i < 4; i++) x_bn[i] = xs[i];
      req      = 4'b0000;
      abort    = 4'b0000;
      gen_busy = 1'b0;

      do_reset();
      chk_reset_vals("rst");

      // Single job for requester 2, operands {3,F,0,8}, busy 16 cycles.
      req = 4'b0100;
      job_ok(2, 16);
      req = 4'b0000;

      // Fairness from a fresh pointer: 0,1,2,3,0,1,2,3 with one idle cycle between.
      do_reset();
      req = 4'b1111;
      for (int j = 0; j < 8; j++) job_ok(j % 4, 3);
      req = 4'b0000;
      tick();

      // Abort by owner 1 at RUN cycle 5; non-owner abort at RUN cycle 3 ignored.
      launch(1, 4'b0010);
      tick();
      gen_busy = 1'b1;
      repeat (3) tick();
      abort = 4'b1101;
      tick();
      abort = 4'b0000;
      chk_eq("nonown_stop", o_gen_stop, 0);
      chk_eq("nonown_busy", o_busy,     1);
      chk_eq("nonown_cnt",  o_run_cnt,  3);
      tick();
      abort = 4'b0010;
      tick();
      abort = 4'b0000;
      chk_eq("abort_stop",  o_gen_stop, 1);
      chk_eq("abort_cnt",   o_run_cnt,  5);
      tick();
      chk_eq("abort_stop_once", o_gen_stop, 0);
      chk_eq("abort_wait_done", o_done,     0);
      gen_busy = 1'b0;
      tick();
      chk_eq("abort_done",   o_done,   4'b0010);
      chk_eq("abort_status", o_status, 1);
      tick();
      chk_eq("abort_idle", o_grant, 0);

      // Busy never rises: stop after the wait window, status TIMEOUT.
      launch(0, 4'b0001);
      repeat (4) tick();
      chk_eq("wto_no_stop", o_gen_stop, 0);
      chk_eq("wto_busy",    o_busy,     1);
      tick();
      chk_eq("wto_stop",    o_gen_stop, 1);
      tick();
      chk_eq("wto_done",    o_done,     4'b0001);
      chk_eq("wto_status",  o_status,   2);
      tick();
      chk_eq("wto_idle",    o_busy,     0);

      // Abort in the same cycle as wait expiry: ABORTED.
      launch(0, 4'b0001);
      repeat (4) tick();
      abort = 4'b0001;
      tick();
      abort = 4'b0000;
      chk_eq("wab_stop",   o_gen_stop, 1);
      tick();
      chk_eq("wab_done",   o_done,     4'b0001);
      chk_eq("wab_status", o_status,   1);
      tick();

      // Busy stuck high: stop when run count reaches 18.
      launch(0, 4'b0001);
      tick();
      gen_busy = 1'b1;
      repeat (18) tick();
      chk_eq("rto_pre_stop", o_gen_stop, 0);
      chk_eq("rto_pre_cnt",  o_run_cnt,  17);
      tick();
      chk_eq("rto_stop",     o_gen_stop, 1);
      chk_eq("rto_cnt",      o_run_cnt,  18);
      tick();
      chk_eq("rto_stop_once", o_gen_stop, 0);
      chk_eq("rto_cnt_sat",   o_run_cnt,  18);
      chk_eq("rto_no_done",   o_done,     0);
      gen_busy = 1'b0;
      tick();
      chk_eq("rto_done",   o_done,   4'b0001);
      chk_eq("rto_status", o_status, 2);
      tick();

      // Abort and busy fall together: completion wins.
      launch(2, 4'b0100);
      tick();
      gen_busy = 1'b1;
      repeat (4) tick();
      gen_busy = 1'b0;
      abort    = 4'b0100;
      tick();
      abort = 4'b0000;
      chk_eq("col_done",    o_done,     4'b0100);
      chk_eq("col_status",  o_status,   0);
      chk_eq("col_no_stop", o_gen_stop, 0);
      chk_eq("col_cnt",     o_run_cnt,  4);
      tick();

      // Reset mid-RUN: outputs return to reset values, pointer back to 0.
      launch(1, 4'b0010);
      tick();
      gen_busy = 1'b1;
      repeat (3) tick();
      chk_eq("mid_run_cnt", o_run_cnt, 2);
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      gen_busy = 1'b0;
      chk_reset_vals("midrst");
      req = 4'b1111;
      job_ok(0, 2);
      req = 4'b0000;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sn_gen_sched.md
# sn_gen_sched

Round-robin scheduler sharing one 4-lane stochastic-number generator (4×4-bit binary operands → four 16-bit bitstreams) among NREQ requesters (conv-layer input ports). It arbitrates requests, latches the winner's operands, pulses start/stop into the generator, tracks the generator's busy flag, and returns a completion pulse with a status code. It sits between the layer sequencers and the generator, and owns the generator's start/stop/operand inputs exclusively.

## Interface
- NREQ, 4: number of requesters (2..8).
- SN_LEN, 16: expected bitstream length in cycles.
- WAIT_MAX, 4: max cycles from start pulse to busy rising.
- i_clk_sched  in  1  clock; the only clock.
- i_rst_sched  in  1  reset; synchronous, active-high.
- i_req  in  NREQ  per-requester request level.
- i_x_bn  in  NREQ×4×4  per-requester operands (4 lanes × 4 bits).
- i_abort  in  NREQ  per-requester abort; only the owner's bit is honoured.
- i_gen_busy  in  1  generator "generating" flag.
- o_grant  out  NREQ  one-hot owner; all-zero when idle.
- o_owner  out  $clog2(NREQ)  owner index; valid while o_grant≠0.
- o_done  out  NREQ  1-cycle completion pulse to the owner.
- o_status  out  2  completion code; valid with o_done.
- o_gen_start  out  1  1-cycle start pulse to the generator.
- o_gen_stop  out  1  1-cycle stop pulse to the generator.
- o_gen_x  out  4×4  latched operands to the generator.
- o_busy  out  1  high whenever state≠IDLE.
- o_run_cnt  out  5  cycles spent in RUN for the current job.

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, RUN, STOP, DONE.
- IDLE: if any i_req, pick the winner round-robin starting at rr_ptr. Register o_grant/o_owner, latch i_x_bn[winner] into o_gen_x, and go to LAUNCH. Set rr_ptr = winner+1 mod NREQ.
- LAUNCH (1 cycle): o_gen_start=1. Go to WAIT_BUSY and clear the wait counter.
- WAIT_BUSY: when i_gen_busy=1, go to RUN. If the wait counter reaches WAIT_MAX, set status TIMEOUT and go to STOP.
- RUN: o_run_cnt increments every cycle. On i_gen_busy=0, go to DONE with status OK. If o_run_cnt reaches SN_LEN+2, set status TIMEOUT and go to STOP.
- Abort: i_abort[owner]=1 in LAUNCH, WAIT_BUSY or RUN sets status ABORTED and goes to STOP. Non-owner abort bits are ignored.
- STOP: o_gen_stop=1 on the first STOP cycle only. Stay in STOP until i_gen_busy=0, then go to DONE.
- DONE (1 cycle): o_done[owner]=1 and o_status is valid; o_grant is still held. Next state is IDLE, where o_grant=0. Requests are re-sampled in IDLE, so a requester still holding i_req competes fresh.
- Status codes: OK=0, ABORTED=1, TIMEOUT=2; 3 is reserved.
- o_gen_x is stable from LAUNCH through DONE.
- o_run_cnt saturates at SN_LEN+2 and clears in LAUNCH.

## Timing
- Reset values: state IDLE, rr_ptr=0, o_grant=0, o_owner=0, o_done=0, o_status=0, o_gen_start=0, o_gen_stop=0, o_gen_x=0, o_busy=0, o_run_cnt=0.
- Reset asserted in any state returns to IDLE next edge. No stop pulse is issued; the generator shares the same reset.
- All outputs are registered.
- Arbitration latency: i_req high in cycle t (IDLE) gives o_grant and o_gen_start in cycle t+1.
- Minimum back-to-back spacing is DONE → IDLE → LAUNCH, so grants are separated by ≥1 idle cycle.
- Simultaneous events:
  - Abort in the same cycle as the busy fall: DONE with OK (completion wins).
  - Abort in the same cycle as the WAIT_MAX expiry: ABORTED wins.
- Nominal OK job: LAUNCH + WAIT_BUSY (generator start latency) + RUN (SN_LEN) + DONE.

## Structure
- Package sn_sched_pkg holds: the state enum, the status enum (OK/ABORTED/TIMEOUT), SN_LANES=4, SN_BITS=4, and the default SN_LEN.
- One sub-module, rr_arbiter: combinational round-robin pick from (req vector, rr_ptr) to (one-hot, index, any). The FSM, counters and operand latch stay in the top module.

## Test plan
- Single job: req[2]=1 with x={4'h3,4'hF,4'h0,4'h8}, generator model busy for 16 cycles → o_gen_start 1 cycle after req, o_gen_x matches x, o_done[2] pulses with status 0, o_run_cnt=16.
- Fairness: req=4'b1111 held for 8 jobs → grant order 0,1,2,3,0,1,2,3, each grant separated by one idle cycle.
- Abort: owner 1 raises i_abort at RUN cycle 5 → one o_gen_stop pulse next cycle; after busy falls, o_done[1] with status 1. A non-owner abort has no effect.
- Timeout: busy never rises → o_gen_stop after WAIT_MAX cycles, o_done with status 2. Busy stuck high → stop at o_run_cnt=18, status 2 once busy falls.
- Collision: abort and busy fall in the same cycle → status 0. Reset asserted mid-RUN → all outputs at reset values next cycle, rr_ptr=0.
